thread_ctx: RTL and testbench
=============================

Name: thread_ctx

Overview:
- Per-thread context block for the Ember thread core: instruction decoder, 40-entry general register file, 40-entry internal-state file and a 4-bit privilege-level register.
- The thread FSM loads a fetched 32-bit word and receives registered decode fields one cycle later.
- The FSM reads registers combinationally and writes them synchronously.

Parameters:
- DATA_W, 64, register and immediate width.
- NUM_REGS, 40, implemented entries per file; addresses 0..NUM_REGS-1 valid, address field 6 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dec_inst  in  32  instruction word.
- dec_imm_in  in  DATA_W  extended immediate.
- dec_imm_in_en  in  1  immediate present.
- dec_opcode  out  12  opcode.
- dec_mode  out  4  addressing mode.
- dec_rsrc  out  6  source register or short immediate.
- dec_rdest  out  6  destination register.
- dec_flags  out  4  flags; bit0 = instruction-valid.
- dec_imm_en  out  1  immediate valid.
- dec_imm_out  out  DATA_W  latched immediate.
- dec_valid  out  1  decoded fields valid.
- rf_wr_en  in  1  register-file write enable.
- rf_wr_addr  in  6  register-file write address.
- rf_wr_data  in  DATA_W  register-file write data.
- rf_rd1_addr  in  6  register-file read port 1 address.
- rf_rd1_data  out  DATA_W  register-file read port 1 data.
- rf_rd2_addr  in  6  register-file read port 2 address.
- rf_rd2_data  out  DATA_W  register-file read port 2 data.
- is_wr_en  in  1  internal-state write enable.
- is_wr_addr  in  6  internal-state write address.
- is_wr_data  in  DATA_W  internal-state write data.
- is_rd1_addr  in  6  internal-state read port 1 address.
- is_rd1_data  out  DATA_W  internal-state read port 1 data.
- is_rd2_addr  in  6  internal-state read port 2 address.
- is_rd2_data  out  DATA_W  internal-state read port 2 data.
- is_pl_wr_en  in  1  privilege-level write enable.
- is_pl_wr_data  in  4  privilege-level write data.
- is_pl  out  4  current privilege level.

Behaviour:
- Reset (async, rst=1):
  - All register-file and internal-state entries = 0.
  - is_pl = 4'h0.
  - All dec_* outputs = 0, dec_valid = 0.
- Decoder field layout: opcode = inst[31:20], mode = [19:16], rsrc = [15:10], rdest = [9:4], flags = [3:0].
- Decoder outputs are registered every clock, so latency is 1 cycle from dec_inst to the outputs. Holding dec_inst stable holds the outputs.
- dec_valid <= inst[0] (flags bit0).
- dec_imm_en <= inst[1] & dec_imm_in_en.
- dec_imm_out <= dec_imm_in when dec_imm_in_en=1; otherwise dec_imm_out holds its value.
- Decoder performs no opcode legality check. Register range checking belongs to the thread FSM.
- Register-file reads are combinational: rd_data = entry[rd_addr].
  - Address >= NUM_REGS reads 0.
  - Both read ports are independent; both may target the same address.
- Register-file writes are synchronous: when wr_en=1 and wr_addr < NUM_REGS, the entry takes wr_data at the edge. Out-of-range writes are silently dropped.
- Read and write to the same address in the same cycle returns the OLD value (no bypass) unless RF_BYPASS_EN is defined. The new value is visible from the next cycle.
- The internal-state file follows the same rules as the register file, with separate storage.
- Privilege level: when is_pl_wr_en=1, is_pl <= is_pl_wr_data at the edge; otherwise it holds.
- Internal-state and privilege-level writes in the same cycle are both performed.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge. Writes presented during reset are dropped.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read of an address being written this cycle (wr_en=1, addr match, in range) returns wr_data combinationally. Applies to both the register file and the internal-state file, on both read ports.
- Undefined: reads return the stored (old) value.

Decomposition:
- Package thread_pkg holds:
  - NUM_REGS default.
  - Field bit positions (OPC_MSB/LSB etc.).
  - FLAG_VALID=0, FLAG_IMM=1.
  - Reset privilege level PL_RESET=4'h0.
  - A packed struct for decoded fields.
- One sub-module is natural: ctx_regfile (parameterised 2R1W array with out-of-range guard and optional bypass). Instantiate it twice, once as the register file and once as the internal-state file.
- The decoder and privilege register stay inline.

Test Plan:
- Decode: dec_inst=32'h1151_5A41 → next cycle opcode=12'h115, mode=4'h1, rsrc=6'h16, rdest=6'h24, flags=4'h1, dec_valid=1, dec_imm_en=0.
- Immediate: inst bit1=1, dec_imm_in_en=1, dec_imm_in=64'hDEAD_BEEF → next cycle dec_imm_en=1, dec_imm_out=64'hDEAD_BEEF. Then imm_in_en=0 → dec_imm_out holds.
- Register file:
  - Write r5=64'h1234.
  - Same-cycle read of r5 gives 0 (bypass off) or 64'h1234 (bypass on).
  - Next cycle rd1=r5 and rd2=r5 both give 64'h1234.
- Bounds: write addr 40 with 64'hFF → no entry changes; read addr 63 → 0; addr 39 read/write works.
- Internal state and privilege level:
  - Write is[3]=64'hA5 and pl=4'h3 in the same cycle → both visible next cycle.
  - Register-file r3 unchanged.
- Async reset mid-operation: assert rst between edges → all reads 0, is_pl=0 and dec_valid=0 immediately. A write issued with rst high is not stored.

Source files
------------

// File: rtl/thread_ctx_pkg.sv
// Shared constants, decode field layout and decoded-field struct for the Ember thread context.
package thread_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 40;
  localparam int ADDR_W   = 6;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 20;
  localparam int MODE_MSB  = 19;
  localparam int MODE_LSB  = 16;
  localparam int RSRC_MSB  = 15;
  localparam int RSRC_LSB  = 10;
  localparam int RDEST_MSB = 9;
  localparam int RDEST_LSB = 4;
  localparam int FLAGS_MSB = 3;
  localparam int FLAGS_LSB = 0;

  localparam int FLAG_VALID = 0;
  localparam int FLAG_IMM   = 1;

  localparam logic [3:0] PL_RESET = 4'h0;

  typedef struct packed {
    logic [11:0] opcode;
    logic [3:0]  mode;
    logic [5:0]  rsrc;
    logic [5:0]  rdest;
    logic [3:0]  flags;
  } dec_fields_t;

  function automatic dec_fields_t decode_fields(input logic [31:0] inst);
    dec_fields_t f;
    f.opcode = inst[OPC_MSB:OPC_LSB];
    f.mode   = inst[MODE_MSB:MODE_LSB];
    f.rsrc   = inst[RSRC_MSB:RSRC_LSB];
    f.rdest  = inst[RDEST_MSB:RDEST_LSB];
    f.flags  = inst[FLAGS_MSB:FLAGS_LSB];
    return f;
  endfunction

endpackage

// File: rtl/thread_ctx_if.sv
// Bundle between the thread FSM (master) and its context block (slave).
interface thread_ctx_if;
  import thread_pkg::*;

  logic [31:0]       dec_inst;
  logic [DATA_W-1:0] dec_imm_in;
  logic              dec_imm_in_en;
  logic [11:0]       dec_opcode;
  logic [3:0]        dec_mode;
  logic [5:0]        dec_rsrc;
  logic [5:0]        dec_rdest;
  logic [3:0]        dec_flags;
  logic              dec_imm_en;
  logic [DATA_W-1:0] dec_imm_out;
  logic              dec_valid;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rf_rd1_addr;
  logic [DATA_W-1:0] rf_rd1_data;
  logic [ADDR_W-1:0] rf_rd2_addr;
  logic [DATA_W-1:0] rf_rd2_data;

  logic              is_wr_en;
  logic [ADDR_W-1:0] is_wr_addr;
  logic [DATA_W-1:0] is_wr_data;
  logic [ADDR_W-1:0] is_rd1_addr;
  logic [DATA_W-1:0] is_rd1_data;
  logic [ADDR_W-1:0] is_rd2_addr;
  logic [DATA_W-1:0] is_rd2_data;
  logic              is_pl_wr_en;
  logic [3:0]        is_pl_wr_data;
  logic [3:0]        is_pl;

  modport master (
    output dec_inst, dec_imm_in, dec_imm_in_en,
    input  dec_opcode, dec_mode, dec_rsrc, dec_rdest, dec_flags,
           dec_imm_en, dec_imm_out, dec_valid,
    output rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd1_addr, rf_rd2_addr,
    input  rf_rd1_data, rf_rd2_data,
    output is_wr_en, is_wr_addr, is_wr_data, is_rd1_addr, is_rd2_addr,
           is_pl_wr_en, is_pl_wr_data,
    input  is_rd1_data, is_rd2_data, is_pl
  );

  modport slave (
    input  dec_inst, dec_imm_in, dec_imm_in_en,
    output dec_opcode, dec_mode, dec_rsrc, dec_rdest, dec_flags,
           dec_imm_en, dec_imm_out, dec_valid,
    input  rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd1_addr, rf_rd2_addr,
    output rf_rd1_data, rf_rd2_data,
    input  is_wr_en, is_wr_addr, is_wr_data, is_rd1_addr, is_rd2_addr,
           is_pl_wr_en, is_pl_wr_data,
    output is_rd1_data, is_rd2_data, is_pl
  );

endinterface

// File: rtl/thread_ctx_regfile.sv
// 2-read/1-write register array with out-of-range guard (reads 0, writes dropped).
// RF_BYPASS_EN: a read of the address being written this cycle returns the write data.
module ctx_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 40,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic [DATA_W-1:0] rd1_data_o,
  input  logic [ADDR_W-1:0] rd2_addr_i,
  output logic [DATA_W-1:0] rd2_data_o
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_hit;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  assign wr_hit = wr_en_i && in_range(wr_addr_i);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) mem_d[wr_addr_i] = wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd1_data_o = '0;
    if (in_range(rd1_addr_i)) rd1_data_o = mem_q[rd1_addr_i];
`ifdef RF_BYPASS_EN
    if (wr_hit && (wr_addr_i == rd1_addr_i)) rd1_data_o = wr_data_i;
`endif
  end

  always_comb begin
    rd2_data_o = '0;
    if (in_range(rd2_addr_i)) rd2_data_o = mem_q[rd2_addr_i];
`ifdef RF_BYPASS_EN
    if (wr_hit && (wr_addr_i == rd2_addr_i)) rd2_data_o = wr_data_i;
`endif
  end

endmodule

// File: rtl/thread_ctx.sv
// Per-thread context: registered instruction decoder, general register file,
// internal-state file and privilege-level register.
module thread_ctx
  import thread_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  thread_ctx_if.slave  ctx
);

  dec_fields_t       dec_q, dec_d;
  logic              valid_q, valid_d;
  logic              imm_en_q, imm_en_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [3:0]        pl_q, pl_d;

  // Immediate and privilege level hold unless explicitly loaded.
  always_comb begin
    dec_d    = decode_fields(ctx.dec_inst);
    valid_d  = ctx.dec_inst[FLAG_VALID];
    imm_en_d = ctx.dec_inst[FLAG_IMM] & ctx.dec_imm_in_en;
    imm_d    = ctx.dec_imm_in_en ? ctx.dec_imm_in : imm_q;
    pl_d     = ctx.is_pl_wr_en ? ctx.is_pl_wr_data : pl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q    <= '0;
      valid_q  <= 1'b0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      pl_q     <= PL_RESET;
    end else begin
      dec_q    <= dec_d;
      valid_q  <= valid_d;
      imm_en_q <= imm_en_d;
      imm_q    <= imm_d;
      pl_q     <= pl_d;
    end
  end

  assign ctx.dec_opcode  = dec_q.opcode;
  assign ctx.dec_mode    = dec_q.mode;
  assign ctx.dec_rsrc    = dec_q.rsrc;
  assign ctx.dec_rdest   = dec_q.rdest;
  assign ctx.dec_flags   = dec_q.flags;
  assign ctx.dec_valid   = valid_q;
  assign ctx.dec_imm_en  = imm_en_q;
  assign ctx.dec_imm_out = imm_q;
  assign ctx.is_pl       = pl_q;

  ctx_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (ctx.rf_wr_en),
    .wr_addr_i  (ctx.rf_wr_addr),
    .wr_data_i  (ctx.rf_wr_data),
    .rd1_addr_i (ctx.rf_rd1_addr),
    .rd1_data_o (ctx.rf_rd1_data),
    .rd2_addr_i (ctx.rf_rd2_addr),
    .rd2_data_o (ctx.rf_rd2_data)
  );

  ctx_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_is (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (ctx.is_wr_en),
    .wr_addr_i  (ctx.is_wr_addr),
    .wr_data_i  (ctx.is_wr_data),
    .rd1_addr_i (ctx.is_rd1_addr),
    .rd1_data_o (ctx.is_rd1_data),
    .rd2_addr_i (ctx.is_rd2_addr),
    .rd2_data_o (ctx.is_rd2_data)
  );

endmodule

// File: tb/tb_thread_ctx.sv
// Directed scoreboard bench for thread_ctx: decode, immediate latch, both register
// files with bounds, privilege level and asynchronous reset mid-operation.
module tb_thread_ctx;
  import thread_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } expect_t;

  expect_t scoreboard[$];
  int      checks   = 0;
  int      failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  thread_ctx_if ctxIf();

  thread_ctx dut (
    .clk (clk),
    .rst (rst),
    .ctx (ctxIf)
  );

`ifdef RF_BYPASS_EN
  localparam logic [63:0] SAME_CYCLE_R5 = 64'h1234;
`else
  localparam logic [63:0] SAME_CYCLE_R5 = 64'h0;
`endif

  task automatic pushExpect(input string tag, input logic [63:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] observed);
    expect_t e;
    checks++;
    if (scoreboard.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<none>", observed);
    end else begin
      e = scoreboard.pop_front();
      assert (observed === e.value) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] immIn,
                               input logic immInEn);
    ctxIf.dec_inst      = inst;
    ctxIf.dec_imm_in    = immIn;
    ctxIf.dec_imm_in_en = immInEn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(32'h0, 64'h0, 1'b0);
    ctxIf.rf_wr_en = 1'b0; ctxIf.rf_wr_addr = '0; ctxIf.rf_wr_data = '0;
    ctxIf.rf_rd1_addr = '0; ctxIf.rf_rd2_addr = '0;
    ctxIf.is_wr_en = 1'b0; ctxIf.is_wr_addr = '0; ctxIf.is_wr_data = '0;
    ctxIf.is_rd1_addr = '0; ctxIf.is_rd2_addr = '0;
    ctxIf.is_pl_wr_en = 1'b0; ctxIf.is_pl_wr_data = '0;
    #2;

    pushExpect("reset_rf_rd1", 64'h0);   checkOutput(ctxIf.rf_rd1_data);
    pushExpect("reset_is_rd1", 64'h0);   checkOutput(ctxIf.is_rd1_data);
    pushExpect("reset_pl", 64'h0);       checkOutput(64'(ctxIf.is_pl));
    pushExpect("reset_valid", 64'h0);    checkOutput(64'(ctxIf.dec_valid));
    pushExpect("reset_opcode", 64'h0);   checkOutput(64'(ctxIf.dec_opcode));
    #2 rst = 1'b0;
    tick();

    // Decode field extraction, one cycle latency.
    applyStimulus(32'h1151_5A41, 64'h0, 1'b0);
    pushExpect("dec_opcode", 64'h115); pushExpect("dec_mode", 64'h1);
    pushExpect("dec_rsrc", 64'h16);    pushExpect("dec_rdest", 64'h24);
    pushExpect("dec_flags", 64'h1);    pushExpect("dec_valid", 64'h1);
    pushExpect("dec_imm_en", 64'h0);
    tick();
    checkOutput(64'(ctxIf.dec_opcode)); checkOutput(64'(ctxIf.dec_mode));
    checkOutput(64'(ctxIf.dec_rsrc));   checkOutput(64'(ctxIf.dec_rdest));
    checkOutput(64'(ctxIf.dec_flags));  checkOutput(64'(ctxIf.dec_valid));
    checkOutput(64'(ctxIf.dec_imm_en));
    pushExpect("dec_hold_opcode", 64'h115);
    tick();
    checkOutput(64'(ctxIf.dec_opcode));

    // Immediate latch then hold.
    applyStimulus(32'h0000_0003, 64'hDEAD_BEEF, 1'b1);
    pushExpect("imm_en", 64'h1); pushExpect("imm_out", 64'hDEAD_BEEF);
    pushExpect("imm_opcode", 64'h0);
    tick();
    checkOutput(64'(ctxIf.dec_imm_en)); checkOutput(ctxIf.dec_imm_out);
    checkOutput(64'(ctxIf.dec_opcode));
    applyStimulus(32'h0000_0003, 64'h1111, 1'b0);
    pushExpect("imm_en_off", 64'h0); pushExpect("imm_hold", 64'hDEAD_BEEF);
    tick();
    checkOutput(64'(ctxIf.dec_imm_en)); checkOutput(ctxIf.dec_imm_out);

    // Register file write r5 with same-cycle read.
    ctxIf.rf_wr_en = 1'b1; ctxIf.rf_wr_addr = 6'd5; ctxIf.rf_wr_data = 64'h1234;
    ctxIf.rf_rd1_addr = 6'd5; ctxIf.rf_rd2_addr = 6'd5;
    #1;
    pushExpect("rf_same_cycle_rd1", SAME_CYCLE_R5); checkOutput(ctxIf.rf_rd1_data);
    pushExpect("rf_same_cycle_rd2", SAME_CYCLE_R5); checkOutput(ctxIf.rf_rd2_data);
    tick();
    ctxIf.rf_wr_en = 1'b0;
    #1;
    pushExpect("rf_r5_rd1", 64'h1234); checkOutput(ctxIf.rf_rd1_data);
    pushExpect("rf_r5_rd2", 64'h1234); checkOutput(ctxIf.rf_rd2_data);

    // Bounds: write to 40 dropped, reads of 40/63 give 0, entry 39 usable.
    ctxIf.rf_wr_en = 1'b1; ctxIf.rf_wr_addr = 6'd40; ctxIf.rf_wr_data = 64'hFF;
    ctxIf.rf_rd1_addr = 6'd40; ctxIf.rf_rd2_addr = 6'd63;
    #1;
    pushExpect("rf_oob_same_cycle", 64'h0); checkOutput(ctxIf.rf_rd1_data);
    tick();
    ctxIf.rf_wr_en = 1'b0;
    #1;
    pushExpect("rf_rd_40", 64'h0); checkOutput(ctxIf.rf_rd1_data);
    pushExpect("rf_rd_63", 64'h0); checkOutput(ctxIf.rf_rd2_data);
    ctxIf.rf_rd1_addr = 6'd5; ctxIf.rf_rd2_addr = 6'd0;
    #1;
    pushExpect("rf_r5_after_oob", 64'h1234); checkOutput(ctxIf.rf_rd1_data);
    pushExpect("rf_r0_after_oob", 64'h0);    checkOutput(ctxIf.rf_rd2_data);
    ctxIf.rf_wr_en = 1'b1; ctxIf.rf_wr_addr = 6'd39; ctxIf.rf_wr_data = 64'h3939;
    tick();
    ctxIf.rf_wr_en = 1'b0; ctxIf.rf_rd1_addr = 6'd39;
    #1;
    pushExpect("rf_r39", 64'h3939); checkOutput(ctxIf.rf_rd1_data);

    // Internal state and privilege written together.
    ctxIf.is_wr_en = 1'b1; ctxIf.is_wr_addr = 6'd3; ctxIf.is_wr_data = 64'hA5;
    ctxIf.is_pl_wr_en = 1'b1; ctxIf.is_pl_wr_data = 4'h3;
    tick();
    ctxIf.is_wr_en = 1'b0; ctxIf.is_pl_wr_en = 1'b0; ctxIf.is_pl_wr_data = 4'hF;
    ctxIf.is_rd1_addr = 6'd3; ctxIf.is_rd2_addr = 6'd5;
    ctxIf.rf_rd1_addr = 6'd3; ctxIf.rf_rd2_addr = 6'd39;
    #1;
    pushExpect("is_r3", 64'hA5);       checkOutput(ctxIf.is_rd1_data);
    pushExpect("is_r5_separate", 64'h0); checkOutput(ctxIf.is_rd2_data);
    pushExpect("pl_written", 64'h3);   checkOutput(64'(ctxIf.is_pl));
    pushExpect("rf_r3_untouched", 64'h0); checkOutput(ctxIf.rf_rd1_data);
    pushExpect("rf_r39_kept", 64'h3939);  checkOutput(ctxIf.rf_rd2_data);
    tick();
    pushExpect("pl_hold", 64'h3); checkOutput(64'(ctxIf.is_pl));

    // Asynchronous reset between edges with writes pending.
    ctxIf.rf_wr_en = 1'b1; ctxIf.rf_wr_addr = 6'd6; ctxIf.rf_wr_data = 64'h5555;
    ctxIf.is_wr_en = 1'b1; ctxIf.is_wr_addr = 6'd4; ctxIf.is_wr_data = 64'h77;
    ctxIf.rf_rd1_addr = 6'd5; ctxIf.is_rd1_addr = 6'd3;
    #2 rst = 1'b1;
    #1;
    pushExpect("arst_rf_r5", 64'h0);  checkOutput(ctxIf.rf_rd1_data);
    pushExpect("arst_is_r3", 64'h0);  checkOutput(ctxIf.is_rd1_data);
    pushExpect("arst_pl", 64'h0);     checkOutput(64'(ctxIf.is_pl));
    pushExpect("arst_valid", 64'h0);  checkOutput(64'(ctxIf.dec_valid));
    pushExpect("arst_imm_out", 64'h0); checkOutput(ctxIf.dec_imm_out);
    tick();
    ctxIf.rf_wr_en = 1'b0; ctxIf.is_wr_en = 1'b0;
    rst = 1'b0;
    ctxIf.rf_rd2_addr = 6'd6; ctxIf.is_rd2_addr = 6'd4;
    #1;
    pushExpect("rst_write_rf_dropped", 64'h0); checkOutput(ctxIf.rf_rd2_data);
    pushExpect("rst_write_is_dropped", 64'h0); checkOutput(ctxIf.is_rd2_data);

    checks++;
    if (scoreboard.size() != 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", scoreboard.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
